// File: rtl/gbd_rom_arbiter.sv
// gbd_rom_arbiter: shares one async ROM/RAM port between cartridge reads
// and host loader transfers; cart always wins, accesses never abort.
module gbd_rom_arbiter #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        cart_stb,
  input  logic [22:0] cart_addr,
  output logic [7:0]  cart_rdata,
  output logic        cart_valid,
  output logic        cart_overrun,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [22:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [22:0] mem_a,
  output logic [7:0]  mem_dq_out,
  output logic        mem_dq_oe,
  input  logic [7:0]  mem_dq_in,
  output logic        mem_ncs,
  output logic        mem_noe,
  output logic        mem_nwe,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CART    = 2'd1;
  localparam logic [1:0] S_HOST    = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        done;
  logic        op_we;
  logic        cart_pend;
  logic [22:0] pend_addr;

  logic in_access;
  logic active;
  logic last;
  logic first;
  logic start_cart;
  logic start_host;
  logic wr;

  assign in_access  = (state == S_CART) || (state == S_HOST);
  assign active     = in_access && !done;
  assign last       = active && (cnt == 4'd0);
  assign first      = active && (cnt == CNT_LOAD);
  assign start_cart = (state == S_IDLE) && (cart_stb || cart_pend);
  assign start_host = (state == S_IDLE) && !start_cart && host_req;
  assign wr         = (state == S_HOST) && op_we;

  // Pending cart request: newest strobe wins, a dropped one is flagged.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cart_pend    <= 1'b0;
      pend_addr    <= '0;
      cart_overrun <= 1'b0;
    end else if (cart_stb) begin
      cart_pend <= 1'b1;
      pend_addr <= cart_addr;
      if (cart_pend) begin
        cart_overrun <= 1'b1;
      end
    end else if (first && (state == S_CART)) begin
      cart_pend <= 1'b0;
    end
  end

  // Arbitration state and access phase tracking.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      op_we <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start_cart) begin
            state <= S_CART;
            cnt   <= CNT_LOAD;
            op_we <= 1'b0;
          end else if (start_host) begin
            state <= S_HOST;
            cnt   <= CNT_LOAD;
            op_we <= host_we;
          end
        end
        S_CART, S_HOST: begin
          if (done) begin
            state <= S_RECOVER;
            done  <= 1'b0;
          end else if (cnt == 4'd0) begin
            done <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RECOVER: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory address: loaded at access start, held while idle.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      mem_a <= '0;
    end else if (start_cart) begin
      mem_a <= cart_stb ? cart_addr : pend_addr;
    end else if (start_host) begin
      mem_a <= host_addr;
    end
  end

  // Read data capture on the final access cycle.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cart_rdata <= '0;
      host_rdata <= '0;
    end else if (last) begin
      if (state == S_CART) begin
        cart_rdata <= mem_dq_in;
      end else if (!op_we) begin
        host_rdata <= mem_dq_in;
      end
    end
  end

  // Completion pulses, one cycle after the final access cycle.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cart_valid <= 1'b0;
      host_ack   <= 1'b0;
    end else begin
      cart_valid <= last && (state == S_CART);
      host_ack   <= last && (state == S_HOST);
    end
  end

  // Strobes decode straight from registered state so reset forces them high.
  always_comb begin
    mem_ncs    = !active;
    mem_noe    = !(active && !wr);
    mem_nwe    = !(active && wr && (cnt != 4'd0));
    mem_dq_oe  = active && wr;
    mem_dq_out = (active && wr) ? host_wdata : 8'h00;
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_gbd_rom_arbiter.sv
// tb_gbd_rom_arbiter: directed vectors plus a transaction-timeline model
// compared against every DUT output on each falling clock edge.
module tb_gbd_rom_arbiter;

  localparam int AC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cart_stb = 1'b0;
  logic [22:0] cart_addr = '0;
  logic [7:0]  cart_rdata;
  logic        cart_valid;
  logic        cart_overrun;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [22:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [22:0] mem_a;
  logic [7:0]  mem_dq_out;
  logic        mem_dq_oe;
  logic [7:0]  mem_dq_in = '0;
  logic        mem_ncs;
  logic        mem_noe;
  logic        mem_nwe;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  int c_nwe = 0;
  int c_oe = 0;
  int c_ack = 0;
  int c_val = 0;

  gbd_rom_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .sys_clock(clk),
    .sys_resetn(rst_n),
    .cart_stb(cart_stb),
    .cart_addr(cart_addr),
    .cart_rdata(cart_rdata),
    .cart_valid(cart_valid),
    .cart_overrun(cart_overrun),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .mem_a(mem_a),
    .mem_dq_out(mem_dq_out),
    .mem_dq_oe(mem_dq_oe),
    .mem_dq_in(mem_dq_in),
    .mem_ncs(mem_ncs),
    .mem_noe(mem_noe),
    .mem_nwe(mem_nwe),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: kind 0 idle, 1 cart, 2 host; age counts cycles since the
  // access was granted (1..AC strobed, AC+1 pulse, AC+2 recover).
  int          m_kind = 0;
  int          m_age = 0;
  logic        m_we = 1'b0;
  logic        m_pend = 1'b0;
  logic [22:0] m_paddr = '0;
  logic        m_ovr = 1'b0;
  logic [22:0] m_a = '0;
  logic [7:0]  m_crd = '0;
  logic [7:0]  m_hrd = '0;

  task automatic model_step();
    logic clr;
    if (!rst_n) begin
      m_kind = 0; m_age = 0; m_we = 1'b0;
      m_pend = 1'b0; m_paddr = '0; m_ovr = 1'b0;
      m_a = '0; m_crd = '0; m_hrd = '0;
      return;
    end
    if (m_kind != 0 && m_age == AC) begin
      if (m_kind == 1) m_crd = mem_dq_in;
      else if (!m_we) m_hrd = mem_dq_in;
    end
    clr = (m_kind == 1) && (m_age == 1);
    if (m_kind != 0) begin
      if (m_age == AC + 2) m_kind = 0;
      else m_age++;
    end else if (cart_stb || m_pend) begin
      m_kind = 1; m_age = 1;
      m_a = cart_stb ? cart_addr : m_paddr;
    end else if (host_req) begin
      m_kind = 2; m_age = 1;
      m_we = host_we; m_a = host_addr;
    end
    if (cart_stb) begin
      if (m_pend) m_ovr = 1'b1;
      m_pend = 1'b1;
      m_paddr = cart_addr;
    end else if (clr) begin
      m_pend = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Compare process plus event counters.
  initial forever begin
    logic act_, wr_, oe_;
    @(negedge clk);
    act_ = (m_kind != 0) && (m_age >= 1) && (m_age <= AC);
    wr_  = (m_kind == 2) && m_we;
    oe_  = act_ && wr_;
    chk("m_ncs", 32'(mem_ncs), 32'(!act_));
    chk("m_noe", 32'(mem_noe), 32'(!(act_ && !wr_)));
    chk("m_nwe", 32'(mem_nwe), 32'(!(oe_ && m_age < AC)));
    chk("m_oe", 32'(mem_dq_oe), 32'(oe_));
    chk("m_dq", 32'(mem_dq_out), 32'(oe_ ? host_wdata : 8'h00));
    chk("m_cv", 32'(cart_valid), 32'(m_kind == 1 && m_age == AC + 1));
    chk("m_ack", 32'(host_ack), 32'(m_kind == 2 && m_age == AC + 1));
    chk("m_busy", 32'(busy), 32'(m_kind != 0));
    chk("m_a", 32'(mem_a), 32'(m_a));
    chk("m_crd", 32'(cart_rdata), 32'(m_crd));
    chk("m_hrd", 32'(host_rdata), 32'(m_hrd));
    chk("m_ovr", 32'(cart_overrun), 32'(m_ovr));
    if (!mem_nwe) c_nwe++;
    if (mem_dq_oe) c_oe++;
    if (host_ack) c_ack++;
    if (cart_valid) c_val++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (host_ack) host_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int s_nwe, s_oe, s_ack, s_val;

  task automatic snap();
    s_nwe = c_nwe; s_oe = c_oe; s_ack = c_ack; s_val = c_val;
  endtask

  initial begin
    run(3);
    chk("rst_ncs", 32'(mem_ncs), 32'd1);
    chk("rst_noe", 32'(mem_noe), 32'd1);
    chk("rst_nwe", 32'(mem_nwe), 32'd1);
    chk("rst_oe", 32'(mem_dq_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a", 32'(mem_a), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Cart read, cycle 0 is the strobe cycle.
    mem_dq_in = 8'hA5;
    cart_stb = 1'b1;
    cart_addr = 23'h004123;
    step();
    cart_stb = 1'b0;
    chk("c1_ncs", 32'(mem_ncs), 32'd0);
    chk("c1_noe", 32'(mem_noe), 32'd0);
    chk("c1_a", 32'(mem_a), 32'h004123);
    run(3);
    chk("c4_ncs", 32'(mem_ncs), 32'd0);
    step();
    chk("c5_ncs", 32'(mem_ncs), 32'd1);
    chk("c5_valid", 32'(cart_valid), 32'd1);
    chk("c5_data", 32'(cart_rdata), 32'hA5);
    step();
    chk("c6_busy", 32'(busy), 32'd1);
    step();
    chk("c7_busy", 32'(busy), 32'd0);

    // Host write at top address.
    snap();
    host_we = 1'b1;
    host_addr = 23'h7FFFFF;
    host_wdata = 8'h3C;
    host_req = 1'b1;
    step();
    chk("hw_dq", 32'(mem_dq_out), 32'h3C);
    run(11);
    chk("hw_nwe_n", c_nwe - s_nwe, 32'd3);
    chk("hw_oe_n", c_oe - s_oe, 32'd4);
    chk("hw_ack_n", c_ack - s_ack, 32'd1);
    chk("hw_dq_idle", 32'(mem_dq_out), 32'h00);
    chk("hw_a_hold", 32'(mem_a), 32'h7FFFFF);

    // Host read.
    snap();
    mem_dq_in = 8'h77;
    host_we = 1'b0;
    host_addr = 23'h000100;
    host_req = 1'b1;
    run(10);
    chk("hr_ack_n", c_ack - s_ack, 32'd1);
    chk("hr_data", 32'(host_rdata), 32'h77);

    // Simultaneous cart and host: cart first, host after recover.
    mem_dq_in = 8'h11;
    cart_stb = 1'b1;
    cart_addr = 23'h000055;
    host_we = 1'b0;
    host_addr = 23'h000AAA;
    host_req = 1'b1;
    step();
    cart_stb = 1'b0;
    chk("sim_a_cart", 32'(mem_a), 32'h000055);
    run(4);
    chk("sim_cv", 32'(cart_valid), 32'd1);
    chk("sim_ack0", 32'(host_ack), 32'd0);
    step();
    mem_dq_in = 8'h22;
    step();
    chk("sim7_ncs", 32'(mem_ncs), 32'd1);
    step();
    chk("sim8_ncs", 32'(mem_ncs), 32'd0);
    chk("sim8_a", 32'(mem_a), 32'h000AAA);
    run(4);
    chk("sim12_ack", 32'(host_ack), 32'd1);
    chk("sim_hrd", 32'(host_rdata), 32'h22);
    chk("sim_crd", 32'(cart_rdata), 32'h11);
    run(3);

    // Three cart strobes during one host write.
    chk("ov_pre", 32'(cart_overrun), 32'd0);
    snap();
    mem_dq_in = 8'h6B;
    host_we = 1'b1;
    host_addr = 23'h100000;
    host_wdata = 8'h5A;
    host_req = 1'b1;
    step();
    cart_stb = 1'b1;
    cart_addr = 23'h000111;
    step();
    cart_addr = 23'h000222;
    step();
    cart_addr = 23'h000333;
    step();
    cart_stb = 1'b0;
    chk("ov_flag", 32'(cart_overrun), 32'd1);
    run(4);
    chk("ov8_ncs", 32'(mem_ncs), 32'd0);
    chk("ov8_a", 32'(mem_a), 32'h000333);
    run(6);
    chk("ov_val_n", c_val - s_val, 32'd1);
    chk("ov_crd", 32'(cart_rdata), 32'h6B);

    // Reset in cycle 2 of a host write.
    host_we = 1'b1;
    host_addr = 23'h0ABCDE;
    host_wdata = 8'hC3;
    host_req = 1'b1;
    step();
    step();
    chk("rs_pre_oe", 32'(mem_dq_oe), 32'd1);
    snap();
    rst_n = 1'b0;
    #1;
    chk("rs_ncs", 32'(mem_ncs), 32'd1);
    chk("rs_nwe", 32'(mem_nwe), 32'd1);
    chk("rs_oe", 32'(mem_dq_oe), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_ovr", 32'(cart_overrun), 32'd0);
    host_req = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(8);
    chk("rs_ack_n", c_ack - s_ack, 32'd0);
    chk("rs_busy2", 32'(busy), 32'd0);

    // Normal cart read after reset.
    mem_dq_in = 8'h9E;
    cart_stb = 1'b1;
    cart_addr = 23'h3FFFFF;
    step();
    cart_stb = 1'b0;
    run(4);
    chk("pr_valid", 32'(cart_valid), 32'd1);
    chk("pr_data", 32'(cart_rdata), 32'h9E);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
